game_countdown_timer: RTL

Parametrised countdown timer for the whack-a-mole game round clock and the per-mole timeout. It replaces derived-clock counting with a single-clock design that uses an internal prescaler, which generates a clock-enable tick at TICK_HZ. It adds runtime load, start, pause, auto-reload and one-cycle expiry pulses. Multiple instances run off CLOCK_50 for different game timers.

---
 rtl/game_countdown_timer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/game_countdown_timer.sv
// Single-clock countdown timer with an internal prescaler producing a tick enable
// at TICK_HZ; supports runtime load, start, pause, auto-reload and expiry pulses.
module game_countdown_timer #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int TICK_HZ      = 1,
    parameter int WIDTH        = 6,
    parameter int DEFAULT_LOAD = 60
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             expired,
    output logic             done,
    output logic             running
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV <= 1) ? 1 : $clog2(DIV);

    localparam logic [PW-1:0]    PSC_MAX  = PW'(DIV - 1);
    localparam logic [PW-1:0]    PSC_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_INIT = WIDTH'(DEFAULT_LOAD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [PW-1:0]    psc_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             tick_q;
    logic             expired_q;
    logic             done_q;
    logic             running_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            psc_q     <= PSC_ZERO;
            count_q   <= CNT_INIT;
            reload_q  <= CNT_INIT;
            tick_q    <= 1'b0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            tick_q    <= 1'b0;
            expired_q <= 1'b0;
            if (load) begin
                reload_q  <= load_value;
                count_q   <= load_value;
                psc_q     <= PSC_ZERO;
                state_q   <= S_IDLE;
                done_q    <= 1'b0;
                running_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            if (count_q != CNT_ZERO) begin
                                state_q   <= S_RUN;
                                psc_q     <= PSC_ZERO;
                                running_q <= 1'b1;
                            end else begin
                                // Starting an empty timer expires at once.
                                state_q   <= S_DONE;
                                expired_q <= 1'b1;
                                done_q    <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        if (!pause) begin
                            if (psc_q == PSC_MAX) begin
                                psc_q  <= PSC_ZERO;
                                tick_q <= 1'b1;
                                if (count_q > CNT_ONE) begin
                                    count_q <= count_q - CNT_ONE;
                                end else if (count_q == CNT_ONE) begin
                                    count_q   <= CNT_ZERO;
                                    expired_q <= 1'b1;
                                    if (!auto_reload) begin
                                        state_q   <= S_DONE;
                                        done_q    <= 1'b1;
                                        running_q <= 1'b0;
                                    end
                                end else begin
                                    // Periodic mode: the zero count lasts one tick before reloading.
                                    count_q <= reload_q;
                                end
                            end else begin
                                psc_q <= psc_q + 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        if (start) begin
                            if (reload_q != CNT_ZERO) begin
                                count_q   <= reload_q;
                                psc_q     <= PSC_ZERO;
                                state_q   <= S_RUN;
                                done_q    <= 1'b0;
                                running_q <= 1'b1;
                            end else begin
                                expired_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q   <= S_IDLE;
                        done_q    <= 1'b0;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign count   = count_q;
    assign tick    = tick_q;
    assign expired = expired_q;
    assign done    = done_q;
    assign running = running_q;

endmodule
